// File: rtl/lda_draw_ctrl.sv
// Avalon-MM slave that holds line operands, fires the LDA datapath on GO and
// tracks busy/done, with stall (waitrequest) or poll software modes.
module lda_draw_ctrl #(
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  output logic [31:0]   avs_readdata,
  output logic          avs_waitrequest,
  output logic          lda_start,
  output logic [XW-1:0] lda_x0,
  output logic [YW-1:0] lda_y0,
  output logic [XW-1:0] lda_x1,
  output logic [YW-1:0] lda_y1,
  output logic [CW-1:0] lda_color,
  input  logic          lda_done
);

  localparam logic [2:0] A_MODE   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_GO     = 3'd2;
  localparam logic [2:0] A_START  = 3'd3;
  localparam logic [2:0] A_END    = 3'd4;
  localparam logic [2:0] A_COLOR  = 3'd5;
  localparam logic [2:0] A_COUNT  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic                overrun_q, overrun_d;
  logic [XW+YW-1:0]    start_q, start_d;
  logic [XW+YW-1:0]    end_q, end_d;
  logic [CW-1:0]       color_q, color_d;
  logic [15:0]         count_q, count_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                wait_q, wait_d;
  logic                pulse_q, pulse_d;
  logic [XW-1:0]       x0_q, x0_d, x1_q, x1_d;
  logic [YW-1:0]       y0_q, y0_d, y1_q, y1_d;
  logic [CW-1:0]       col_q, col_d;

  logic                acc_rd_s, acc_wr_s, go_s, busy_s;
  logic [31:0]         rd_mux_s;
  logic                unused_wd;

  assign unused_wd = ^avs_writedata;

  assign acc_rd_s = avs_read & ~wait_q;
  assign acc_wr_s = avs_write & ~wait_q;
  assign go_s     = acc_wr_s & (avs_address == A_GO);
  assign busy_s   = (state_q != S_IDLE);

  // Read-data multiplexer; unused bits and unmapped addresses return zero.
  always_comb begin
    rd_mux_s = 32'd0;
    case (avs_address)
      A_MODE:   rd_mux_s = {31'd0, mode_q};
      A_STATUS: rd_mux_s = {30'd0, overrun_q, busy_s};
      A_START:  rd_mux_s = {{(32-XW-YW){1'b0}}, start_q};
      A_END:    rd_mux_s = {{(32-XW-YW){1'b0}}, end_q};
      A_COLOR:  rd_mux_s = {{(32-CW){1'b0}}, color_q};
      A_COUNT:  rd_mux_s = {16'd0, count_q};
      default:  rd_mux_s = 32'd0;
    endcase
  end

  // Next-state logic: sequencer, register writes, read capture, bus stall.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    overrun_d = overrun_q;
    start_d   = start_q;
    end_d     = end_q;
    color_d   = color_q;
    count_d   = count_q;
    rdata_d   = rdata_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    col_d     = col_q;

    case (state_q)
      S_IDLE: begin
        if (go_s) begin
          state_d = S_START;
          x0_d    = start_q[XW-1:0];
          y0_d    = start_q[XW+YW-1:XW];
          x1_d    = end_q[XW-1:0];
          y1_d    = end_q[XW+YW-1:XW];
          col_d   = color_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: state_d = S_BUSY;
      S_BUSY: begin
        if (lda_done) begin
          state_d = S_IDLE;
          count_d = count_q + 16'd1;
        end else begin
          state_d = S_BUSY;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A GO that cannot start a line (including one racing lda_done) is an overrun.
    if (acc_wr_s) begin
      case (avs_address)
        A_MODE:   mode_d    = avs_writedata[0];
        A_STATUS: overrun_d = 1'b0;
        A_GO: begin
          if (busy_s) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
        end
        A_START:  start_d = avs_writedata[XW+YW-1:0];
        A_END:    end_d   = avs_writedata[XW+YW-1:0];
        A_COLOR:  color_d = avs_writedata[CW-1:0];
        default:  mode_d  = mode_q;
      endcase
    end else begin
      mode_d = mode_q;
    end

    if (acc_rd_s) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = rdata_q;
    end

    wait_d  = (state_d != S_IDLE) & ~mode_d;
    pulse_d = (state_d == S_START);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      overrun_q <= 1'b0;
      start_q   <= '0;
      end_q     <= '0;
      color_q   <= '0;
      count_q   <= 16'd0;
      rdata_q   <= 32'd0;
      wait_q    <= 1'b0;
      pulse_q   <= 1'b0;
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      col_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      overrun_q <= overrun_d;
      start_q   <= start_d;
      end_q     <= end_d;
      color_q   <= color_d;
      count_q   <= count_d;
      rdata_q   <= rdata_d;
      wait_q    <= wait_d;
      pulse_q   <= pulse_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      col_q     <= col_d;
    end
  end

  assign avs_readdata    = rdata_q;
  assign avs_waitrequest = wait_q;
  assign lda_start       = pulse_q;
  assign lda_x0          = x0_q;
  assign lda_y0          = y0_q;
  assign lda_x1          = x1_q;
  assign lda_y1          = y1_q;
  assign lda_color       = col_q;

endmodule

// File: tb/tb_lda_draw_ctrl.sv
// Directed bench for lda_draw_ctrl: register-map vector table plus
// hand-written line, stall, overrun, count-wrap and mid-line reset sequences.
module tb_lda_draw_ctrl;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 3;

  logic          clk;
  logic          reset;
  logic [2:0]    avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic          avs_waitrequest;
  logic          lda_start;
  logic [XW-1:0] lda_x0, lda_x1;
  logic [YW-1:0] lda_y0, lda_y1;
  logic [CW-1:0] lda_color;
  logic          lda_done;

  logic done_man, done_auto, dp_en;
  int   dp_cnt;
  int   n_chk, n_bad;

  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vq[$];

  lda_draw_ctrl #(.XW(XW), .YW(YW), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest), .lda_start(lda_start),
    .lda_x0(lda_x0), .lda_y0(lda_y0), .lda_x1(lda_x1), .lda_y1(lda_y1),
    .lda_color(lda_color), .lda_done(lda_done)
  );

  assign lda_done = done_man | done_auto;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: one-cycle done 40 cycles after the start pulse.
  always @(negedge clk) begin
    if (dp_en && lda_start) begin
      dp_cnt    <= 40;
      done_auto <= 1'b0;
    end else if (dp_cnt == 1) begin
      dp_cnt    <= 0;
      done_auto <= 1'b1;
    end else begin
      if (dp_cnt != 0) dp_cnt <= dp_cnt - 1;
      done_auto <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, output int waits);
    avs_address = a; avs_writedata = d; avs_write = 1'b1; waits = 0;
    while (avs_waitrequest && waits < 200) begin tick(); waits++; end
    if (avs_waitrequest) chk("write_timeout", 32'd1, 32'd0);
    tick();
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output int waits);
    avs_address = a; avs_read = 1'b1; waits = 0;
    while (avs_waitrequest && waits < 200) begin tick(); waits++; end
    if (avs_waitrequest) chk("read_timeout", 32'd1, 32'd0);
    tick();
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    int w;
    bus_write(a, d, w);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    int w;
    bus_read(a, d, w);
    chk(name, d, exp);
  endtask

  task automatic pulse_done();
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int w;
    n_chk = 0; n_bad = 0;
    reset = 1'b1; avs_address = 3'd0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = 32'd0; done_man = 1'b0; dp_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wait", {31'd0, avs_waitrequest}, 32'd0);
    chk("rst_start", {31'd0, lda_start}, 32'd0);
    chk("rst_rdata", avs_readdata, 32'd0);
    reset = 1'b0;
    tick();

    // Register map vectors: {write, address, writedata, expected readdata}
    vq.push_back({1'b0, 3'd0, 32'h0,        32'h0});
    vq.push_back({1'b0, 3'd1, 32'h0,        32'h0});
    vq.push_back({1'b0, 3'd6, 32'h0,        32'h0});
    vq.push_back({1'b0, 3'd7, 32'h0,        32'h0});
    vq.push_back({1'b0, 3'd3, 32'h0,        32'h0});
    vq.push_back({1'b1, 3'd7, 32'hFFFFFFFF, 32'h0});
    vq.push_back({1'b0, 3'd7, 32'h0,        32'h0});
    vq.push_back({1'b1, 3'd6, 32'hFFFFFFFF, 32'h0});
    vq.push_back({1'b0, 3'd6, 32'h0,        32'h0});
    vq.push_back({1'b1, 3'd0, 32'hFFFFFFFF, 32'h0});
    vq.push_back({1'b0, 3'd0, 32'h0,        32'h1});
    vq.push_back({1'b1, 3'd3, 32'hFFFFFFFF, 32'h0});
    vq.push_back({1'b0, 3'd3, 32'h0,        32'h0001FFFF});
    vq.push_back({1'b1, 3'd5, 32'hFFFFFFFF, 32'h0});
    vq.push_back({1'b0, 3'd5, 32'h0,        32'h7});
    vq.push_back({1'b1, 3'd3, 32'h0000280A, 32'h0});
    vq.push_back({1'b0, 3'd3, 32'h0,        32'h0000280A});
    vq.push_back({1'b1, 3'd4, 32'h00006464, 32'h0});
    vq.push_back({1'b0, 3'd4, 32'h0,        32'h00006464});
    vq.push_back({1'b1, 3'd5, 32'h3,        32'h0});
    vq.push_back({1'b0, 3'd5, 32'h0,        32'h3});
    vq.push_back({1'b0, 3'd1, 32'h0,        32'h0});
    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].wr) begin
        bus_write(vq[i].addr, vq[i].data, w);
        chk("vec_wr_wait", w, 32'd0);
      end else begin
        bus_read(vq[i].addr, d, w);
        chk("vec_rd", d, vq[i].exp);
      end
    end
    chk("shadow_not_latched_x0", {23'd0, lda_x0}, 32'd0);

    // Poll-mode line (MODE=1 from the table)
    wr(3'd2, 32'd0);
    chk("go_start_pulse", {31'd0, lda_start}, 32'd1);
    chk("go_x0", {23'd0, lda_x0}, 32'd10);
    chk("go_y0", {24'd0, lda_y0}, 32'd20);
    chk("go_x1", {23'd0, lda_x1}, 32'd100);
    chk("go_y1", {24'd0, lda_y1}, 32'd50);
    chk("go_color", {29'd0, lda_color}, 32'd3);
    tick();
    chk("start_one_cycle", {31'd0, lda_start}, 32'd0);
    rd_chk("poll_status_busy", 3'd1, 32'd1);
    pulse_done();
    rd_chk("poll_status_idle", 3'd1, 32'd0);
    rd_chk("poll_count1", 3'd6, 32'd1);

    // Stall mode: status read is held until the cycle after done
    wr(3'd0, 32'd0);
    dp_en = 1'b1;
    bus_write(3'd2, 32'd0, w);
    chk("stall_go_wait", w, 32'd0);
    bus_read(3'd1, d, w);
    chk("stall_wait_cycles", w, 32'd41);
    chk("stall_status", d, 32'd0);
    dp_en = 1'b0;
    rd_chk("stall_count2", 3'd6, 32'd2);

    // Poll mode overrun: operands frozen, sticky flag, clear by write to 1
    wr(3'd0, 32'd1);
    wr(3'd2, 32'd0);
    wr(3'd4, 32'h00000A05);
    wr(3'd2, 32'd0);
    chk("ovr_x1_kept", {23'd0, lda_x1}, 32'd100);
    chk("ovr_y1_kept", {24'd0, lda_y1}, 32'd50);
    rd_chk("ovr_status_busy", 3'd1, 32'd3);
    pulse_done();
    rd_chk("ovr_status_idle", 3'd1, 32'd2);
    wr(3'd1, 32'd0);
    rd_chk("ovr_cleared", 3'd1, 32'd0);

    // GO in the same cycle as done is an overrun and starts nothing
    wr(3'd2, 32'd0);
    chk("relatch_x1", {23'd0, lda_x1}, 32'd5);
    chk("relatch_y1", {24'd0, lda_y1}, 32'd5);
    tick();
    avs_address = 3'd2; avs_write = 1'b1; done_man = 1'b1;
    tick();
    avs_write = 1'b0; done_man = 1'b0;
    chk("race_no_start", {31'd0, lda_start}, 32'd0);
    tick();
    chk("race_no_start2", {31'd0, lda_start}, 32'd0);
    rd_chk("race_status", 3'd1, 32'd2);
    rd_chk("race_count4", 3'd6, 32'd4);
    wr(3'd1, 32'd0);

    // done outside BUSY is ignored
    repeat (3) begin pulse_done(); tick(); end
    rd_chk("idle_done_count", 3'd6, 32'd4);

    // Counter wrap from 0xFFFF
    force dut.count_q = 16'hFFFF;
    tick();
    release dut.count_q;
    rd_chk("preload_count", 3'd6, 32'h0000FFFF);
    wr(3'd2, 32'd0);
    tick();
    pulse_done();
    rd_chk("count_wrap", 3'd6, 32'd0);

    // Reset 10 cycles into BUSY in stall mode with a read pending
    wr(3'd0, 32'd0);
    wr(3'd2, 32'd0);
    avs_address = 3'd1; avs_read = 1'b1;
    chk("pend_wait_start", {31'd0, avs_waitrequest}, 32'd1);
    repeat (11) tick();
    chk("pend_wait_busy", {31'd0, avs_waitrequest}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mrst_wait", {31'd0, avs_waitrequest}, 32'd0);
    chk("mrst_start", {31'd0, lda_start}, 32'd0);
    chk("mrst_x0", {23'd0, lda_x0}, 32'd0);
    chk("mrst_x1", {23'd0, lda_x1}, 32'd0);
    chk("mrst_color", {29'd0, lda_color}, 32'd0);
    avs_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    rd_chk("mrst_status", 3'd1, 32'd0);
    rd_chk("mrst_mode", 3'd0, 32'd0);
    rd_chk("mrst_count", 3'd6, 32'd0);
    rd_chk("mrst_start_reg", 3'd3, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
